tft_ahb_sram: RTL
=================

Name: tft_ahb_sram

Overview:
- AHB-Lite responder fronting a single-port synchronous SRAM that holds the TFT framebuffer.
- Serves the TFT DMA master's incrementing read bursts and CPU-side framebuffer writes.
- Sits on the HCLK domain between the AHB interconnect and the SRAM macro.
- Zero-wait reads and writes; one wait state only when a read collides with a pending write; standard two-cycle ERROR for bad accesses.

Parameters:
- BASE_ADDR, 32'h0, byte address of word 0 of the SRAM window.
- MEM_WORDS, 4096, SRAM depth in 32-bit words.
- MEM_AW, $clog2(MEM_WORDS), SRAM word-address width (derived).

Ports:
- HCLK  in  1  bus clock, sole clock.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  AHB_PKG::trans_t.
- HBURST  in  3  AHB_PKG::burst_t (accepted, unused).
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- MEM_EN  out  1  SRAM access strobe.
- MEM_WE  out  4  per-byte write enables.
- MEM_ADDR  out  MEM_AW  word address.
- MEM_WDATA  out  32  write data.
- MEM_RDATA  in  32  read data, valid exactly 1 cycle after a MEM_EN read.

Behaviour:
- Reset (synchronous, HRESET=1 at a HCLK edge): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, MEM_EN=0, MEM_WE=0. All pending phases are discarded, including a transfer in flight.
- Accept condition: HSEL & HREADY & HTRANS in {NONSEQ, SEQ}.
- IDLE/BUSY, or HSEL=0 with HREADY=1: next data phase is OKAY with zero wait.
- Error check in the address phase. Any of the following makes the transfer an ERROR:
  - HADDR < BASE_ADDR;
  - HADDR >= BASE_ADDR + 4*MEM_WORDS;
  - HSIZE > 3'b010;
  - misalignment: HSIZE=halfword with HADDR[0]=1, or HSIZE=word with HADDR[1:0]!=0.
- ERROR response and SRAM side effects:
  - Data phase cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
  - No SRAM access for the errored transfer.
  - An address phase presented during ERROR cycle 2 is accepted normally.
- States: IDLE, RD (read data phase), WR (write data phase), RD_STALL, ERR1, ERR2.
- Read, no conflict:
  - Issued combinationally in the accept cycle: MEM_EN=1, MEM_WE=0, MEM_ADDR = (HADDR-BASE_ADDR)>>2.
  - Next cycle RD: HRDATA = MEM_RDATA, HREADYOUT=1. Latency 0 wait states.
- Write:
  - Address phase registers address, HSIZE and byte-lane mask.
  - Data phase WR: MEM_EN=1, MEM_WE = lane mask, MEM_WDATA = HWDATA, HREADYOUT=1.
  - Lane mask for byte: 1 << addr[1:0]. Halfword: 2'b11 << {addr[1],1'b0}. Word: 4'hF.
- Conflict: a read accepted while the current cycle is WR data phase (port busy).
  - Read is not issued in that cycle; its address is registered.
  - Next cycle RD_STALL: MEM_EN=1 from the registered address, HREADYOUT=0.
  - Following cycle RD: HREADYOUT=1, data returned. Exactly 1 wait state.
  - Write-then-read of the same word returns the new data, because the write commits before the stalled read.
- While HREADYOUT=0, no new address phase is accepted; the master holds it, and it is accepted on the completing cycle.
- HRDATA is 0 in every non-RD cycle. Out-of-range data is never forwarded.
- HBURST is ignored: every beat is decoded independently, including wrap and increment across the 1 KB boundary.
- Back-to-back SEQ reads sustain 1 word per cycle with no bubbles.

Decomposition:
- AHB_PKG (existing) supplies trans_t and burst_t.
- Add to AHB_PKG:
  - size_t enum (BYTE, HALF, WORD);
  - resp constants OKAY/ERROR;
  - function lane_mask(size, addr[1:0]).
- Optional sub-module tft_ahb_decode: combinational range/alignment check plus lane mask. The FSM stays in the top.

Test Plan:
- Reset mid-read: HRESET=1 during an RD phase -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, MEM_EN=0.
- 8-beat INCR8 read from BASE_ADDR, SRAM preloaded word i = 32'hA000_0000+i -> HRDATA = A000_0000..A000_0007 on 8 consecutive cycles, HREADYOUT=1 throughout.
- Byte write 8'h5A to BASE_ADDR+6 -> MEM_WE=4'b0100, MEM_ADDR=1. Read of BASE_ADDR+4 returns only byte 2 changed.
- Word write 32'hDEAD_BEEF to BASE_ADDR+0x10 immediately followed by a read of the same address -> exactly one HREADYOUT=0 cycle, then HRDATA=32'hDEAD_BEEF.
- Read at BASE_ADDR + 4*MEM_WORDS -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1), MEM_EN=0. Repeat with a word access at BASE_ADDR+2 -> same ERROR response.
- HTRANS=BUSY between SEQ beats, and HSEL=0 cycles -> OKAY, zero wait, no MEM_EN; the burst resumes with correct data.

Source files
------------

// File: rtl/tft_ahb_sram_pkg.sv
// Shared AHB-Lite types, response codes, controller states and the byte-lane helper.
package tft_ahb_sram_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011,
        BURST_WRAP8  = 3'b100,
        BURST_INCR8  = 3'b101,
        BURST_WRAP16 = 3'b110,
        BURST_INCR16 = 3'b111
    } burst_t;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } size_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // state       | meaning
    // ST_IDLE     | no data phase in progress
    // ST_RD       | read data phase, SRAM data forwarded to HRDATA
    // ST_WR       | write data phase, SRAM written from HWDATA
    // ST_RD_STALL | read deferred behind a write, SRAM read issued now
    // ST_ERR1     | first ERROR cycle (HREADYOUT low)
    // ST_ERR2     | second ERROR cycle (HREADYOUT high)
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_STALL = 3'd3,
        ST_ERR1     = 3'd4,
        ST_ERR2     = 3'd5
    } state_t;

    // Byte-lane write enables for a transfer of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << addr_lo;
            SIZE_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tft_ahb_sram_decode.sv
// Address-phase decode: window range check, size/alignment check, word address and lane mask.
module tft_ahb_sram_decode
    import tft_ahb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MEM_WORDS = 4096,
    parameter int          MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic [31:0]       addr,
    input  logic [2:0]        size,
    output logic              err,
    output logic [MEM_AW-1:0] word_addr,
    output logic [3:0]        mask
);

    // Computed one bit wider so a window ending at the top of the map cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) * 33'd4);

    logic [31:0] offset;
    logic        below;
    logic        above;
    logic        bad_size;
    logic        misaligned;
    logic        unused_offset;

    // Range, size and alignment checks are purely combinational on the address phase.
    always_comb begin
        offset     = addr - BASE_ADDR;
        below      = (addr < BASE_ADDR);
        above      = ({1'b0, addr} >= LIMIT);
        bad_size   = (size > 3'd2);
        misaligned = ((size == SIZE_HALF) && addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
        err        = below | above | bad_size | misaligned;
        word_addr  = offset[MEM_AW+1:2];
        mask       = lane_mask(size, addr[1:0]);
    end

    assign unused_offset = ^offset;

endmodule

// File: rtl/tft_ahb_sram.sv
// AHB-Lite responder in front of the single-port TFT framebuffer SRAM.
module tft_ahb_sram
    import tft_ahb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MEM_WORDS = 4096,
    parameter int          MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HBURST,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              MEM_EN,
    output logic [3:0]        MEM_WE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA
);

    state_t            state_q;
    state_t            state_d;
    logic [MEM_AW-1:0] wr_addr_q;
    logic [3:0]        wr_mask_q;
    logic [MEM_AW-1:0] rd_addr_q;
    logic              wr_capture;
    logic              rd_capture;
    logic              accept;
    logic              dec_err;
    logic [MEM_AW-1:0] dec_word_addr;
    logic [3:0]        dec_mask;
    logic              unused_burst;

    // Every beat is decoded on its own; the burst type carries no information here.
    assign unused_burst = ^HBURST;

    tft_ahb_sram_decode #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS),
        .MEM_AW    (MEM_AW)
    ) u_decode (
        .addr      (HADDR),
        .size      (HSIZE),
        .err       (dec_err),
        .word_addr (dec_word_addr),
        .mask      (dec_mask)
    );

    // Address phase is taken only for real transfers; reset suppresses any new access.
    assign accept = HSEL && HREADY && !HRESET &&
                    ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

    // State register plus the write and deferred-read address holders.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            wr_mask_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (wr_capture) begin
                wr_addr_q <= dec_word_addr;
                wr_mask_q <= dec_mask;
            end
            if (rd_capture) begin
                rd_addr_q <= dec_word_addr;
            end
        end
    end

    // Data-phase outputs from the current state; next state and read issue from the address phase.
    always_comb begin
        state_d    = ST_IDLE;
        HREADYOUT  = 1'b1;
        HRESP      = RESP_OKAY;
        HRDATA     = '0;
        MEM_EN     = 1'b0;
        MEM_WE     = '0;
        MEM_ADDR   = '0;
        MEM_WDATA  = '0;
        wr_capture = 1'b0;
        rd_capture = 1'b0;

        case (state_q)
            ST_RD: begin
                HRDATA = MEM_RDATA;
            end
            ST_WR: begin
                MEM_EN    = 1'b1;
                MEM_WE    = wr_mask_q;
                MEM_ADDR  = wr_addr_q;
                MEM_WDATA = HWDATA;
            end
            ST_RD_STALL: begin
                HREADYOUT = 1'b0;
                MEM_EN    = 1'b1;
                MEM_ADDR  = rd_addr_q;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
            end
            ST_ERR2: begin
                HRESP = RESP_ERROR;
            end
            default: ;
        endcase

        if (state_q == ST_RD_STALL) begin
            state_d = ST_RD;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            if (dec_err) begin
                state_d = ST_ERR1;
            end else if (HWRITE) begin
                state_d    = ST_WR;
                wr_capture = 1'b1;
            end else if (state_q == ST_WR) begin
                // SRAM port is busy with the write this cycle; read goes out next cycle.
                state_d    = ST_RD_STALL;
                rd_capture = 1'b1;
            end else begin
                state_d  = ST_RD;
                MEM_EN   = 1'b1;
                MEM_ADDR = dec_word_addr;
            end
        end
    end

endmodule
